// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex 7-segment driver with per-digit blanking and decimal points.
// Optional LEADING_ZERO_BLANK_EN auto-blanks leading zero digits above digit 0.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_blank, blk, an_on;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [3:0]              nib;
    logic [6:0]              font, seg_on;
    logic                    dp_on, tick;
    assign tick   = cnt == CW'(SCAN_DIV - 1);
    assign nib    = sh_val[{idx, 2'b00} +: 4];
    assign seg_on = blk[idx] ? 7'h00 : font;
    assign dp_on  = sh_dp[idx] & ~blk[idx];
    assign an_on  = NUM_DIGITS'(1) << idx;
    always_comb begin
        case (nib)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h79;
            default: font = 7'h71;
        endcase
    end
`ifdef LEADING_ZERO_BLANK_EN
    // zero stays set while every nibble from the top down to digit i is 0
    always_comb begin
        logic zero;
        zero = 1'b1;
        blk  = sh_blank;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero   = zero & (sh_val[4*i +: 4] == 4'h0);
            blk[i] = blk[i] | zero;
        end
    end
`else
    assign blk = sh_blank;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            cnt      <= '0;
            idx      <= '0;
            seg      <= {7{ACTIVE_LOW}};
            dp       <= ACTIVE_LOW;
            an       <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            seg <= seg_on ^ {7{ACTIVE_LOW}};
            dp  <= dp_on ^ ACTIVE_LOW;
            an  <= an_on ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end
endmodule
